// File: rtl/asic_iopoc_pkg.sv
// Shared types for the padring poc sequencer: state encoding and the
// segment-index width helper.
package asic_iopoc_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_UP_STEP = 3'd1;
  localparam logic [2:0] ST_UP_WAIT = 3'd2;
  localparam logic [2:0] ST_ON      = 3'd3;
  localparam logic [2:0] ST_DN_STEP = 3'd4;
  localparam logic [2:0] ST_DN_WAIT = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    UP_STEP = ST_UP_STEP,
    UP_WAIT = ST_UP_WAIT,
    ON      = ST_ON,
    DN_STEP = ST_DN_STEP,
    DN_WAIT = ST_DN_WAIT
  } state_t;

  // Segment index width, never narrower than one bit (NSEG=1 still needs idx).
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/asic_iopoc_timer.sv
// Loadable CW-wide down-counter with zero flag. Serves the stagger delay and,
// with ASIC_IOPOC_ACK_EN, the supply-detector timeout.
module asic_iopoc_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/asic_iopoc_seq.sv
// Padring power-on-control sequencer. Releases poc one supply segment at a
// time (ascending idx) with a programmable stagger, and re-asserts it in
// descending order. Optional macro ASIC_IOPOC_ACK_EN adds per-segment supply
// acknowledge (seg_ok) with a timeout that raises sticky err and ramps down.
// Handshake: req_on/req_off are level requests sampled every cycle; a request
// not acted on in the current state is dropped, nothing is queued.
module asic_iopoc_seq
  import asic_iopoc_pkg::*;
#(
  parameter int NSEG = 4,
  parameter int CW   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_on,
  input  logic            req_off,
  input  logic [NSEG-1:0] seg_en,
  input  logic [CW-1:0]   dly,
`ifdef ASIC_IOPOC_ACK_EN
  input  logic [NSEG-1:0] seg_ok,
  output logic            err,
`endif
  output logic [NSEG-1:0] poc,
  output logic            busy,
  output logic            on,
  output logic            done,
  output state_t          dbg_state
);

  localparam int IDXW = idx_width(NSEG);
  localparam logic [IDXW-1:0] LAST = IDXW'(NSEG - 1);

  state_t          state, state_n;
  logic [IDXW-1:0] idx, idx_n;
  logic [NSEG-1:0] mask, mask_n;
  logic [NSEG-1:0] poc_n;
  logic            tmr_ld, tmr_dec, tmr_zero, adv;
  logic [CW-1:0]   tmr_val;
`ifdef ASIC_IOPOC_ACK_EN
  logic            tmo, tmo_n, err_n;
`endif

  asic_iopoc_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_ld),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Next-state, index, latched mask and poc update.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    mask_n  = mask;
    poc_n   = poc;
    tmr_ld  = 1'b0;
    tmr_val = dly;
    tmr_dec = 1'b0;
    adv     = 1'b0;
`ifdef ASIC_IOPOC_ACK_EN
    tmo_n   = tmo;
    err_n   = err;
`endif
    case (state)
      IDLE: begin
        if (req_on && !req_off) begin
          mask_n  = seg_en;
          idx_n   = '0;
          state_n = UP_STEP;
`ifdef ASIC_IOPOC_ACK_EN
          err_n   = 1'b0;
`endif
        end
      end
      UP_STEP: begin
`ifdef ASIC_IOPOC_ACK_EN
        tmo_n = 1'b0;
`endif
        if (req_off) begin
          state_n = DN_STEP;
        end else if (mask[idx]) begin
          poc_n[idx] = 1'b0;
          tmr_ld     = 1'b1;
          state_n    = UP_WAIT;
        end else if (idx == LAST) begin
          state_n = ON;
        end else begin
          idx_n = idx + IDXW'(1);
        end
      end
      UP_WAIT: begin
        if (req_off) begin
          state_n = DN_STEP;
`ifdef ASIC_IOPOC_ACK_EN
          tmo_n   = 1'b0;
`endif
        end else if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
`ifdef ASIC_IOPOC_ACK_EN
          if (seg_ok[idx]) begin
            tmo_n = 1'b0;
            adv   = 1'b1;
          end else if (!tmo) begin
            // Stagger expired without ack: start 2^CW-cycle timeout window.
            tmo_n   = 1'b1;
            tmr_ld  = 1'b1;
            tmr_val = '1;
          end else begin
            tmo_n   = 1'b0;
            err_n   = 1'b1;
            state_n = DN_STEP;
          end
`else
          adv = 1'b1;
`endif
          if (adv) begin
            if (idx == LAST) begin
              state_n = ON;
            end else begin
              idx_n   = idx + IDXW'(1);
              state_n = UP_STEP;
            end
          end
        end
      end
      ON: begin
        if (req_off) begin
          idx_n   = LAST;
          state_n = DN_STEP;
        end
      end
      DN_STEP: begin
        if (mask[idx]) begin
          poc_n[idx] = 1'b1;
          tmr_ld     = 1'b1;
          state_n    = DN_WAIT;
        end else if (idx == '0) begin
          state_n = IDLE;
        end else begin
          idx_n = idx - IDXW'(1);
        end
      end
      DN_WAIT: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if (idx == '0) begin
          state_n = IDLE;
        end else begin
          idx_n   = idx - IDXW'(1);
          state_n = DN_STEP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      mask  <= '0;
`ifdef ASIC_IOPOC_ACK_EN
      tmo   <= 1'b0;
      err   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      idx   <= idx_n;
      mask  <= mask_n;
`ifdef ASIC_IOPOC_ACK_EN
      tmo   <= tmo_n;
      err   <= err_n;
`endif
    end
  end

  // Registered outputs; done fires on the first ON/IDLE cycle after a ramp.
  always_ff @(posedge clk) begin
    if (reset) begin
      poc  <= '1;
      busy <= 1'b0;
      on   <= 1'b0;
      done <= 1'b0;
    end else begin
      poc  <= poc_n;
      busy <= (state   inside {UP_STEP, UP_WAIT, DN_STEP, DN_WAIT}) ||
              (state_n inside {UP_STEP, UP_WAIT, DN_STEP, DN_WAIT});
      on   <= (state == ON);
      done <= busy && ((state == IDLE) || (state == ON));
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_asic_iopoc_seq.sv
// Directed bench for asic_iopoc_seq (NSEG=4). Cycle 0 is the cycle in which
// a request is driven; checks happen 1 ns after each rising edge.
module tb_asic_iopoc_seq;
  import asic_iopoc_pkg::*;

  localparam int NSEG = 4;
`ifdef ASIC_IOPOC_ACK_EN
  localparam int CW = 4;
`else
  localparam int CW = 8;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            req_on, req_off;
  logic [NSEG-1:0] seg_en;
  logic [CW-1:0]   dly;
  logic [NSEG-1:0] poc;
  logic            busy, on, done;
  state_t          dbg_state;
`ifdef ASIC_IOPOC_ACK_EN
  logic [NSEG-1:0] seg_ok;
  logic            err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // clock / reset
  always #5 clk = ~clk;

  asic_iopoc_seq #(.NSEG(NSEG), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_on    (req_on),
    .req_off   (req_off),
    .seg_en    (seg_en),
    .dly       (dly),
`ifdef ASIC_IOPOC_ACK_EN
    .seg_ok    (seg_ok),
    .err       (err),
`endif
    .poc       (poc),
    .busy      (busy),
    .on        (on),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; req_on = 1'b0; req_off = 1'b0; seg_en = '0; dly = '0;
`ifdef ASIC_IOPOC_ACK_EN
    seg_ok = '1;
`endif
    repeat (3) tick();
    chk("rst_poc", poc, 4'hf);
    chk("rst_busy", busy, 0);
    chk("rst_on", on, 0);
    chk("rst_done", done, 0);
    chk("rst_state", dbg_state, IDLE);
    reset = 1'b0;
    tick();

    // 1: full power-up, dly=3, all segments
    cyc = 0; dly = 3; seg_en = 4'hf; req_on = 1'b1;
    tick(); req_on = 1'b0;
    chk("t1_busy1", busy, 1);
    chk("t1_poc1", poc, 4'hf);
    goto(2);  chk("t1_poc2", poc, 4'he);
    goto(3);  seg_en = 4'h0;
    goto(6);  chk("t1_poc6", poc, 4'he);
    goto(7);  chk("t1_poc7", poc, 4'hc);
    goto(12); chk("t1_poc12", poc, 4'h8);
    goto(17); chk("t1_poc17", poc, 4'h0);
    goto(21); chk("t1_busy21", busy, 1); chk("t1_on21", on, 0); chk("t1_done21", done, 0);
    goto(22); chk("t1_done22", done, 1); chk("t1_on22", on, 1); chk("t1_busy22", busy, 0);
    goto(23); chk("t1_done23", done, 0); req_on = 1'b1;
    // 2: req_on ignored in ON, then ramp down
    tick(); req_on = 1'b0; req_off = 1'b1;
    chk("t2_on24", on, 1); chk("t2_busy24", busy, 0);
    tick(); req_off = 1'b0;
    chk("t2_poc25", poc, 4'h0); chk("t2_busy25", busy, 1);
    goto(26); chk("t2_poc26", poc, 4'h8); chk("t2_on26", on, 0);
    goto(30); chk("t2_poc30", poc, 4'h8);
    goto(31); chk("t2_poc31", poc, 4'hc);
    goto(36); chk("t2_poc36", poc, 4'he);
    goto(41); chk("t2_poc41", poc, 4'hf);
    goto(45); chk("t2_done45", done, 0); chk("t2_busy45", busy, 1);
    goto(46); chk("t2_done46", done, 1); chk("t2_busy46", busy, 0);
    goto(47); chk("t2_done47", done, 0); chk("t2_state47", dbg_state, IDLE);

    // 3: sparse mask 0101, dly=0
    cyc = 0; seg_en = 4'h5; dly = 0; req_on = 1'b1;
    tick(); req_on = 1'b0;
    goto(2);  chk("t3_poc2", poc, 4'he);
    goto(4);  chk("t3_poc4", poc, 4'he);
    goto(5);  chk("t3_poc5", poc, 4'ha);
    goto(7);  chk("t3_done7", done, 0); chk("t3_on7", on, 0);
    goto(8);  chk("t3_done8", done, 1); chk("t3_on8", on, 1); chk("t3_poc8", poc, 4'ha);
    goto(9);  req_off = 1'b1;
    tick(); req_off = 1'b0;
    goto(11); chk("t3_poc11", poc, 4'ha);
    goto(12); chk("t3_poc12", poc, 4'he);
    goto(15); chk("t3_poc15", poc, 4'hf);
    goto(16); chk("t3_done16", done, 0);
    goto(17); chk("t3_done17", done, 1); chk("t3_busy17", busy, 0);

    // 4: abort one cycle after poc[1] falls
    goto(20);
    cyc = 0; seg_en = 4'hf; dly = 3; req_on = 1'b1;
    tick(); req_on = 1'b0;
    goto(7);  chk("t4_poc7", poc, 4'hc);
    goto(8);  req_off = 1'b1;
    tick(); req_off = 1'b0;
    chk("t4_poc9", poc, 4'hc);
    goto(10); chk("t4_poc10", poc, 4'he);
    goto(14); chk("t4_poc14", poc, 4'he);
    goto(15); chk("t4_poc15", poc, 4'hf);
    goto(19); chk("t4_done19", done, 0); chk("t4_busy19", busy, 1);
    goto(20); chk("t4_done20", done, 1); chk("t4_on20", on, 0); chk("t4_state20", dbg_state, IDLE);

    // 5: both requests in IDLE, then reset mid UP_WAIT
    goto(22);
    cyc = 0; req_on = 1'b1; req_off = 1'b1;
    tick(); req_on = 1'b0; req_off = 1'b0;
    chk("t5_busy1", busy, 0); chk("t5_state1", dbg_state, IDLE); chk("t5_poc1", poc, 4'hf);
    goto(3);  chk("t5_done3", done, 0);
    cyc = 0; req_on = 1'b1;
    tick(); req_on = 1'b0;
    goto(3);  chk("t5_wait3", dbg_state, UP_WAIT); chk("t5_poc3", poc, 4'he);
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk("t5_rpoc", poc, 4'hf); chk("t5_rbusy", busy, 0); chk("t5_rstate", dbg_state, IDLE);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_nodone", done, 0);
    end

`ifdef ASIC_IOPOC_ACK_EN
    // 6: seg_ok[1] stuck low -> timeout, err, automatic ramp-down
    cyc = 0; seg_ok = 4'hd; seg_en = 4'hf; dly = 3; req_on = 1'b1;
    tick(); req_on = 1'b0;
    goto(26); chk("t6_err26", err, 0); chk("t6_poc26", poc, 4'hc);
    goto(27); chk("t6_err27", err, 1);
    goto(28); chk("t6_poc28", poc, 4'he);
    goto(38); chk("t6_done38", done, 1); chk("t6_poc38", poc, 4'hf); chk("t6_err38", err, 1);
    goto(40); seg_ok = 4'hf; req_on = 1'b1;
    tick(); req_on = 1'b0;
    chk("t6_errclr", err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
